// File: rtl/codec_pkg.sv
// Shared constants and FSM encoding for the audio codec serial receive path.
package codec_pkg;

    localparam int SAMPLE_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT,
        WAIT
    } state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/codec_adc_rx_if.sv
// Codec ADC serial pins plus the parallel sample bus produced from them.
interface codec_adc_rx_if #(
    parameter int SAMPLE_W = 16
);
    logic                AUD_BCLK;
    logic                AUD_ADCLRCK;
    logic                AUD_ADCDAT;
    logic [SAMPLE_W-1:0] left_out;
    logic [SAMPLE_W-1:0] right_out;
    logic                sample_valid;
    logic                frame_err;

    modport master (
        output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
        input  left_out, right_out, sample_valid, frame_err
    );

    modport slave (
        input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
        output left_out, right_out, sample_valid, frame_err
    );
endinterface

// File: rtl/codec_sync_edge.sv
// N-flop synchronizer for an asynchronous clock-like input, with a one-cycle rise strobe.
module codec_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
endmodule

// File: rtl/codec_adc_rx.sv
// Codec ADC deserializer: I2S or left-justified serial stream to paired 16-bit L/R samples
// in the clk_50 domain.
module codec_adc_rx
    import codec_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int I2S_MODE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk_50,
    input  logic           ar,
    codec_adc_rx_if.slave  aud
);
    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    logic                   bclk_rise;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   lr;
    logic                   dat;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SAMPLE_W-1:0]    shreg;
    logic [SAMPLE_W-1:0]    left_hold;
    logic                   left_done;
    logic                   channel;
    logic                   lr_prev;
    logic                   primed;

    logic [SAMPLE_W-1:0]    left_q;
    logic [SAMPLE_W-1:0]    right_q;
    logic                   valid_q;
    logic                   err_q;

    logic                   lr_edge;
    logic                   last_bit;
    logic                   word_done;
    logic                   cut_short;
    logic [SAMPLE_W-1:0]    next_word;

    codec_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_bclk_sync (
        .clk   (clk_50),
        .rst_n (ar),
        .din   (aud.AUD_BCLK),
        .rise  (bclk_rise)
    );

    always_ff @(posedge clk_50 or negedge ar) begin
        if (!ar) begin
            lr_sync  <= '0;
            dat_sync <= '0;
        end else begin
            lr_sync  <= {lr_sync[SYNC_STAGES-2:0], aud.AUD_ADCLRCK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], aud.AUD_ADCDAT};
        end
    end

    assign lr        = lr_sync[SYNC_STAGES-1];
    assign dat       = dat_sync[SYNC_STAGES-1];
    // First rise after reset only learns the current LRCK level, so a reset never fakes an edge.
    assign lr_edge   = primed && (lr != lr_prev);
    assign last_bit  = (state == SHIFT) && (cnt == CNT_W'(SAMPLE_W - 1));
    assign next_word = {shreg[SAMPLE_W-2:0], dat};

    // In I2S the bit on the LRCK-edge rise still belongs to the old word when it is exactly one short.
    always_comb begin
        word_done = 1'b0;
        cut_short = 1'b0;
        if (bclk_rise) begin
            if (lr_edge) begin
                if (last_bit && (I2S_MODE != 0))
                    word_done = 1'b1;
                else if (state == SHIFT)
                    cut_short = 1'b1;
            end else if (last_bit) begin
                word_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge ar) begin
        if (!ar) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            left_hold <= '0;
            left_done <= 1'b0;
            channel   <= CH_LEFT;
            lr_prev   <= 1'b0;
            primed    <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (bclk_rise) begin
                lr_prev <= lr;
                primed  <= 1'b1;

                if (word_done) begin
                    if (channel == CH_LEFT) begin
                        left_hold <= next_word;
                        left_done <= 1'b1;
                    end else if (channel == CH_RIGHT && left_done) begin
                        left_q    <= left_hold;
                        right_q   <= next_word;
                        valid_q   <= 1'b1;
                        left_done <= 1'b0;
                    end
                end

                if (cut_short) begin
                    err_q <= 1'b1;
                    if (channel == CH_LEFT)
                        left_done <= 1'b0;
                end

                if (lr_edge) begin
                    channel <= lr;
                    if (I2S_MODE != 0) begin
                        state <= SKIP;
                        cnt   <= '0;
                    end else begin
                        state <= SHIFT;
                        shreg <= next_word;
                        cnt   <= CNT_W'(1);
                    end
                end else begin
                    case (state)
                        SKIP: begin
                            shreg <= next_word;
                            cnt   <= CNT_W'(1);
                            state <= SHIFT;
                        end
                        SHIFT: begin
                            shreg <= next_word;
                            cnt   <= cnt + CNT_W'(1);
                            if (last_bit)
                                state <= WAIT;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign aud.left_out     = left_q;
    assign aud.right_out    = right_q;
    assign aud.sample_valid = valid_q;
    assign aud.frame_err    = err_q;
endmodule

// File: tb/tb_codec_adc_rx.sv
// Directed bench for codec_adc_rx: one I2S instance and one left-justified instance share the pins.
module tb_codec_adc_rx;

    logic clk = 1'b0;
    logic ar;
    logic bclk;
    logic lrck;
    logic dat;
    logic carry;

    int n_cmp = 0;
    int n_bad = 0;
    int nv_i2s = 0;
    int ne_i2s = 0;
    int nv_lj  = 0;
    int ne_lj  = 0;
    int v0;
    int e0;

    always #10 clk = ~clk;

    codec_adc_rx_if #(.SAMPLE_W(16)) if_i2s ();
    codec_adc_rx_if #(.SAMPLE_W(16)) if_lj ();

    assign if_i2s.AUD_BCLK    = bclk;
    assign if_i2s.AUD_ADCLRCK = lrck;
    assign if_i2s.AUD_ADCDAT  = dat;
    assign if_lj.AUD_BCLK     = bclk;
    assign if_lj.AUD_ADCLRCK  = lrck;
    assign if_lj.AUD_ADCDAT   = dat;

    codec_adc_rx #(.SAMPLE_W(16), .I2S_MODE(1), .SYNC_STAGES(2)) dut_i2s (
        .clk_50 (clk),
        .ar     (ar),
        .aud    (if_i2s.slave)
    );

    codec_adc_rx #(.SAMPLE_W(16), .I2S_MODE(0), .SYNC_STAGES(2)) dut_lj (
        .clk_50 (clk),
        .ar     (ar),
        .aud    (if_lj.slave)
    );

    always @(posedge clk) begin
        if (if_i2s.sample_valid) nv_i2s <= nv_i2s + 1;
        if (if_i2s.frame_err)    ne_i2s <= ne_i2s + 1;
        if (if_lj.sample_valid)  nv_lj  <= nv_lj + 1;
        if (if_lj.frame_err)     ne_lj  <= ne_lj + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Data and LRCK change while BCLK is low; the codec's rising edge is the sampling edge.
    task automatic bclk_cycle(input logic lr, input logic d);
        lrck = lr;
        dat  = d;
        bclk = 1'b0;
        #80;
        bclk = 1'b1;
        #80;
    endtask

    task automatic i2s_chan(input logic lr, input logic [15:0] w, input int slot);
        bclk_cycle(lr, carry);
        for (int i = 1; i < slot; i++)
            bclk_cycle(lr, (i - 1 < 16) ? w[15 - (i - 1)] : 1'b0);
        carry = (slot == 16) ? w[0] : 1'b0;
    endtask

    task automatic lj_chan(input logic lr, input logic [15:0] w, input int slot);
        for (int i = 0; i < slot; i++)
            bclk_cycle(lr, (i < 16) ? w[15 - i] : 1'b0);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] l, input logic [15:0] r);
        chk({tag, "_left"},  {16'h0, if_i2s.left_out},  {16'h0, l});
        chk({tag, "_right"}, {16'h0, if_i2s.right_out}, {16'h0, r});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bclk  = 1'b0;
        lrck  = 1'b1;
        dat   = 1'b0;
        carry = 1'b0;
        ar    = 1'b0;
        repeat (3) @(negedge clk);
        #5;

        chk("rst_left",  {16'h0, if_i2s.left_out},  32'h0);
        chk("rst_right", {16'h0, if_i2s.right_out}, 32'h0);
        chk("rst_valid", {31'h0, if_i2s.sample_valid}, 32'h0);
        chk("rst_err",   {31'h0, if_i2s.frame_err},    32'h0);

        ar = 1'b1;
        #80;
        repeat (4) bclk_cycle(1'b1, 1'b0);

        // I2S, 32-bit slots
        v0 = nv_i2s; e0 = ne_i2s;
        i2s_chan(1'b0, 16'h1234, 32);
        i2s_chan(1'b1, 16'hABCD, 32);
        chk("i2s32_valid", nv_i2s - v0, 1);
        chk("i2s32_err",   ne_i2s - e0, 0);
        chk_out("i2s32", 16'h1234, 16'hABCD);

        // Left-justified, 32-bit slots
        v0 = nv_lj; e0 = ne_lj;
        lj_chan(1'b0, 16'h8000, 32);
        lj_chan(1'b1, 16'h7FFF, 32);
        chk("lj_valid", nv_lj - v0, 1);
        chk("lj_err",   ne_lj - e0, 0);
        chk("lj_left",  {16'h0, if_lj.left_out},  32'h8000);
        chk("lj_right", {16'h0, if_lj.right_out}, 32'h7FFF);

        // I2S exact fit, 16-bit slots: each LSB rides the next LRCK-edge rise
        v0 = nv_i2s; e0 = ne_i2s;
        i2s_chan(1'b0, 16'h00FF, 16);
        i2s_chan(1'b1, 16'hFF00, 16);
        bclk_cycle(1'b0, carry);
        carry = 1'b0;
        repeat (20) bclk_cycle(1'b1, 1'b0);
        chk("fit_valid", nv_i2s - v0, 1);
        chk("fit_err",   ne_i2s - e0, 0);
        chk_out("fit", 16'h00FF, 16'hFF00);

        // Left word cut after 10 bits
        v0 = nv_i2s; e0 = ne_i2s;
        bclk_cycle(1'b0, carry);
        for (int i = 0; i < 10; i++) bclk_cycle(1'b0, 1'b1);
        i2s_chan(1'b1, 16'h1111, 32);
        chk("cut_err",   ne_i2s - e0, 1);
        chk("cut_valid", nv_i2s - v0, 0);
        chk_out("cut_hold", 16'h00FF, 16'hFF00);
        v0 = nv_i2s; e0 = ne_i2s;
        i2s_chan(1'b0, 16'h5555, 32);
        i2s_chan(1'b1, 16'hAAAA, 32);
        chk("recov_valid", nv_i2s - v0, 1);
        chk("recov_err",   ne_i2s - e0, 0);
        chk_out("recov", 16'h5555, 16'hAAAA);

        // Reset after 8 right bits
        i2s_chan(1'b0, 16'h1357, 32);
        bclk_cycle(1'b1, carry);
        for (int i = 0; i < 8; i++) bclk_cycle(1'b1, i[0]);
        ar = 1'b0;
        #1;
        chk("midrst_left",  {16'h0, if_i2s.left_out},  32'h0);
        chk("midrst_right", {16'h0, if_i2s.right_out}, 32'h0);
        chk("midrst_valid", {31'h0, if_i2s.sample_valid}, 32'h0);
        chk("midrst_err",   {31'h0, if_i2s.frame_err},    32'h0);
        #79;
        ar = 1'b1;
        v0 = nv_i2s; e0 = ne_i2s;
        repeat (23) bclk_cycle(1'b1, 1'b1);
        i2s_chan(1'b0, 16'hC001, 32);
        chk("post_rst_novalid", nv_i2s - v0, 0);
        i2s_chan(1'b1, 16'h0FF0, 32);
        chk("f1_valid", nv_i2s - v0, 1);
        chk_out("f1", 16'hC001, 16'h0FF0);
        i2s_chan(1'b0, 16'h7E57, 32);
        i2s_chan(1'b1, 16'h8421, 32);
        chk("f2_valid", nv_i2s - v0, 2);
        chk_out("f2", 16'h7E57, 16'h8421);
        i2s_chan(1'b0, 16'hFFFF, 32);
        i2s_chan(1'b1, 16'h0001, 32);
        chk("f3_valid", nv_i2s - v0, 3);
        chk_out("f3", 16'hFFFF, 16'h0001);
        chk("post_rst_err", ne_i2s - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
